// File: rtl/inoutptr_multi.sv
// ============================================================================
// inoutptr_multi : multi-push/multi-pop ring-buffer pointer and occupancy manager
// Rev 1.0
// ============================================================================
`default_nettype none

module inoutptr_multi #(
  parameter int SIZE      = 32,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  localparam int PW = $clog2(SIZE),
  localparam int CW = $clog2(SIZE + 1),
  localparam int IW = $clog2(IN_WIDTH + 1),
  localparam int OW = $clog2(OUT_WIDTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clear,
  input  logic          i_in_valid,
  input  logic [IW-1:0] i_in_cnt,
  output logic [PW-1:0] o_in_ptr,
  output logic          o_in_phase,
  input  logic          i_out_valid,
  input  logic [OW-1:0] i_out_cnt,
  output logic [PW-1:0] o_out_ptr,
  output logic          o_out_phase,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_free_cnt,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_overflow,
  output logic          o_underflow
);

  localparam logic [PW:0]   c_SIZE_PTR = (PW + 1)'(SIZE);
  localparam logic [CW-1:0] c_SIZE_CNT = CW'(SIZE);

  logic [PW-1:0] in_ptr_q,  in_ptr_d;
  logic [PW-1:0] out_ptr_q, out_ptr_d;
  logic          in_phase_q,  in_phase_d;
  logic          out_phase_q, out_phase_d;
  logic [CW-1:0] count_q,   count_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  logic [CW-1:0] free_cnt;
  logic          push_ok;
  logic          pop_ok;
  logic [CW:0]   acc_in_cnt;
  logic [CW:0]   acc_out_cnt;

  // Wrap-aware advance; SIZE may be non-power-of-two, so wrap by compare/subtract.
  function automatic logic [PW:0] advance(input logic [PW-1:0] ptr,
                                          input logic          phase,
                                          input logic [PW:0]   n);
    logic [PW:0] s;
    s = {1'b0, ptr} + n;
    if (s >= c_SIZE_PTR) begin
      advance = {~phase, PW'(s - c_SIZE_PTR)};
    end else begin
      advance = {phase, PW'(s)};
    end
  endfunction

  assign free_cnt = c_SIZE_CNT - count_q;

  // Acceptance is judged only against registered state.
  assign push_ok = i_in_valid  && ((CW + 1)'(i_in_cnt)  <= {1'b0, free_cnt});
  assign pop_ok  = i_out_valid && ((CW + 1)'(i_out_cnt) <= {1'b0, count_q});

  assign acc_in_cnt  = push_ok ? (CW + 1)'(i_in_cnt)  : '0;
  assign acc_out_cnt = pop_ok  ? (CW + 1)'(i_out_cnt) : '0;

  always_comb begin
    in_ptr_d    = in_ptr_q;
    in_phase_d  = in_phase_q;
    out_ptr_d   = out_ptr_q;
    out_phase_d = out_phase_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_clear) begin
      in_ptr_d    = '0;
      in_phase_d  = 1'b0;
      out_ptr_d   = '0;
      out_phase_d = 1'b0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        {in_phase_d, in_ptr_d} = advance(in_ptr_q, in_phase_q, (PW + 1)'(i_in_cnt));
      end else if (i_in_valid) begin
        overflow_d = 1'b1;
      end
      if (pop_ok) begin
        {out_phase_d, out_ptr_d} = advance(out_ptr_q, out_phase_q, (PW + 1)'(i_out_cnt));
      end else if (i_out_valid) begin
        underflow_d = 1'b1;
      end
      count_d = CW'({1'b0, count_q} + acc_in_cnt - acc_out_cnt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      in_ptr_q    <= '0;
      in_phase_q  <= 1'b0;
      out_ptr_q   <= '0;
      out_phase_q <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      in_ptr_q    <= in_ptr_d;
      in_phase_q  <= in_phase_d;
      out_ptr_q   <= out_ptr_d;
      out_phase_q <= out_phase_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_in_ptr    = in_ptr_q;
  assign o_in_phase  = in_phase_q;
  assign o_out_ptr   = out_ptr_q;
  assign o_out_phase = out_phase_q;
  assign o_count     = count_q;
  assign o_free_cnt  = free_cnt;
  assign o_full      = (count_q == c_SIZE_CNT);
  assign o_empty     = (count_q == '0);
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

`ifdef SIMULATION
  logic [PW:0] sim_diff_raw;
  logic [PW:0] sim_diff;
  logic [CW:0] sim_cnt_mod;

  assign sim_diff_raw = {1'b0, in_ptr_q} + c_SIZE_PTR - {1'b0, out_ptr_q};
  assign sim_diff     = (sim_diff_raw >= c_SIZE_PTR) ? sim_diff_raw - c_SIZE_PTR : sim_diff_raw;
  assign sim_cnt_mod  = (count_q == c_SIZE_CNT) ? '0 : (CW + 1)'(count_q);

  always @(posedge i_clk) begin
    if (i_reset_n) begin
      if (i_in_valid && (i_in_cnt > IW'(IN_WIDTH)))
        $fatal(1, "inoutptr_multi: i_in_cnt above IN_WIDTH");
      if (i_out_valid && (i_out_cnt > OW'(OUT_WIDTH)))
        $fatal(1, "inoutptr_multi: i_out_cnt above OUT_WIDTH");
      if ((CW + 1)'(sim_diff) != sim_cnt_mod)
        $fatal(1, "inoutptr_multi: pointer distance disagrees with count");
      if ((in_ptr_q == out_ptr_q) && (in_phase_q == out_phase_q) && !o_empty)
        $fatal(1, "inoutptr_multi: equal pointers/phases but not empty");
      if ((in_ptr_q == out_ptr_q) && (in_phase_q != out_phase_q) && !o_full)
        $fatal(1, "inoutptr_multi: equal pointers, opposite phases but not full");
      if ((free_cnt + count_q) != c_SIZE_CNT)
        $fatal(1, "inoutptr_multi: free + count != SIZE");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inoutptr_multi.sv
// Scoreboard bench for inoutptr_multi: a SIZE=32 and a SIZE=5 instance share clock/reset/clear.
`default_nettype none

module tb_inoutptr_multi;

  localparam int SA = 32;
  localparam int SB = 5;

  logic       clk;
  logic       rst_n;
  logic       clr;

  logic       a_inv, a_outv;
  logic [1:0] a_inc, a_outc;
  logic [4:0] a_in_ptr, a_out_ptr;
  logic       a_in_ph, a_out_ph, a_full, a_empty, a_ovf, a_unf;
  logic [5:0] a_count, a_free;

  logic       b_inv, b_outv;
  logic [1:0] b_inc, b_outc;
  logic [2:0] b_in_ptr, b_out_ptr;
  logic       b_in_ph, b_out_ph, b_full, b_empty, b_ovf, b_unf;
  logic [2:0] b_count, b_free;

  inoutptr_multi #(.SIZE(SA), .IN_WIDTH(2), .OUT_WIDTH(2)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr),
    .i_in_valid(a_inv), .i_in_cnt(a_inc), .o_in_ptr(a_in_ptr), .o_in_phase(a_in_ph),
    .i_out_valid(a_outv), .i_out_cnt(a_outc), .o_out_ptr(a_out_ptr), .o_out_phase(a_out_ph),
    .o_count(a_count), .o_free_cnt(a_free), .o_full(a_full), .o_empty(a_empty),
    .o_overflow(a_ovf), .o_underflow(a_unf)
  );

  inoutptr_multi #(.SIZE(SB), .IN_WIDTH(2), .OUT_WIDTH(2)) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clr),
    .i_in_valid(b_inv), .i_in_cnt(b_inc), .o_in_ptr(b_in_ptr), .o_in_phase(b_in_ph),
    .i_out_valid(b_outv), .i_out_cnt(b_outc), .o_out_ptr(b_out_ptr), .o_out_phase(b_out_ph),
    .o_count(b_count), .o_free_cnt(b_free), .o_full(b_full), .o_empty(b_empty),
    .o_overflow(b_ovf), .o_underflow(b_unf)
  );

  typedef struct {
    int in_ptr;
    int in_ph;
    int out_ptr;
    int out_ph;
    int count;
    int ovf;
    int unf;
  } st_t;

  st_t ma, mb;
  st_t qa[$];
  st_t qb[$];
  int  n_vec;
  int  n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic st_t step(input st_t m, input int S, input logic rn, input logic cl,
                               input logic iv, input int ic, input logic ov, input int oc);
    st_t r;
    r = m;
    if (!rn || cl) begin
      r = '{default: 0};
      return r;
    end
    if (iv) begin
      if (ic <= S - m.count) begin
        r.in_ptr = m.in_ptr + ic;
        if (r.in_ptr >= S) begin
          r.in_ptr = r.in_ptr - S;
          r.in_ph  = 1 - m.in_ph;
        end
        r.count = r.count + ic;
      end else begin
        r.ovf = 1;
      end
    end
    if (ov) begin
      if (oc <= m.count) begin
        r.out_ptr = m.out_ptr + oc;
        if (r.out_ptr >= S) begin
          r.out_ptr = r.out_ptr - S;
          r.out_ph  = 1 - m.out_ph;
        end
        r.count = r.count - oc;
      end else begin
        r.unf = 1;
      end
    end
    return r;
  endfunction

  task automatic cmp_a(input st_t e);
    check("a.in_ptr",   32'(a_in_ptr),  e.in_ptr);
    check("a.in_ph",    32'(a_in_ph),   e.in_ph);
    check("a.out_ptr",  32'(a_out_ptr), e.out_ptr);
    check("a.out_ph",   32'(a_out_ph),  e.out_ph);
    check("a.count",    32'(a_count),   e.count);
    check("a.free",     32'(a_free),    SA - e.count);
    check("a.full",     32'(a_full),    32'(e.count == SA));
    check("a.empty",    32'(a_empty),   32'(e.count == 0));
    check("a.overflow", 32'(a_ovf),     e.ovf);
    check("a.underflow",32'(a_unf),     e.unf);
  endtask

  task automatic cmp_b(input st_t e);
    check("b.in_ptr",   32'(b_in_ptr),  e.in_ptr);
    check("b.in_ph",    32'(b_in_ph),   e.in_ph);
    check("b.out_ptr",  32'(b_out_ptr), e.out_ptr);
    check("b.out_ph",   32'(b_out_ph),  e.out_ph);
    check("b.count",    32'(b_count),   e.count);
    check("b.free",     32'(b_free),    SB - e.count);
    check("b.full",     32'(b_full),    32'(e.count == SB));
    check("b.empty",    32'(b_empty),   32'(e.count == 0));
    check("b.overflow", 32'(b_ovf),     e.ovf);
    check("b.underflow",32'(b_unf),     e.unf);
  endtask

  // Predict both instances from the stimulus now on the pins, then compare after the edge.
  task automatic tick();
    st_t ea, eb;
    ea = step(ma, SA, rst_n, clr, a_inv, int'(a_inc), a_outv, int'(a_outc));
    eb = step(mb, SB, rst_n, clr, b_inv, int'(b_inc), b_outv, int'(b_outc));
    qa.push_back(ea);
    qb.push_back(eb);
    ma = ea;
    mb = eb;
    @(posedge clk);
    #1;
    cmp_a(qa.pop_front());
    cmp_b(qb.pop_front());
  endtask

  task automatic set_a(input logic iv, input int ic, input logic ov, input int oc);
    a_inv = iv; a_inc = 2'(ic); a_outv = ov; a_outc = 2'(oc);
  endtask

  task automatic set_b(input logic iv, input int ic, input logic ov, input int oc);
    b_inv = iv; b_inc = 2'(ic); b_outv = ov; b_outc = 2'(oc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bops_push[4];
    int bops_pop[3];
    bops_push = '{2, 2, 2, 1};
    bops_pop  = '{2, 2, 1};
    n_vec = 0;
    n_err = 0;
    ma = '{default: 0};
    mb = '{default: 0};
    rst_n = 1'b0;
    clr   = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Fill A to full, then one rejected push.
    for (int i = 0; i < 16; i++) begin set_a(1, 2, 0, 0); tick(); end
    set_a(1, 1, 0, 0); tick();
    set_a(0, 0, 0, 0);

    // Non-power-of-two ring on B.
    for (int i = 0; i < 4; i++) begin set_b(1, bops_push[i], 0, 0); tick(); end
    set_b(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin set_b(0, 0, 1, bops_pop[i]); tick(); end
    set_b(0, 0, 0, 0);

    // Full A: pop accepted, same-cycle push rejected.
    set_a(1, 2, 1, 2); tick();

    // Clear with same-cycle push.
    clr = 1'b1; set_a(1, 2, 0, 0); tick(); clr = 1'b0;

    // Count 3, then simultaneous push/pop of 2.
    set_a(1, 2, 0, 0); tick();
    set_a(1, 1, 0, 0); tick();
    set_a(1, 2, 1, 2); tick();

    // Empty: push 2 + pop 1 -> pop rejected.
    clr = 1'b1; set_a(0, 0, 0, 0); tick(); clr = 1'b0;
    set_a(1, 2, 1, 1); tick();

    // Reach count 7 with both sticky flags set, then clear with a push.
    for (int i = 0; i < 15; i++) begin set_a(1, 2, 0, 0); tick(); end
    set_a(1, 1, 0, 0); tick();
    for (int i = 0; i < 12; i++) begin set_a(0, 0, 1, 2); tick(); end
    set_a(0, 0, 1, 1); tick();
    clr = 1'b1; set_a(1, 2, 0, 0); tick(); clr = 1'b0;

    // Random legal traffic with a reset dropped in mid-stream.
    for (int i = 0; i < 300; i++) begin
      set_a(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      set_b(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      if (i == 200) begin
        rst_n = 1'b0;
        #2;
        check("a.count_before_reset_edge", 32'(a_count), ma.count);
        check("b.count_before_reset_edge", 32'(b_count), mb.count);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
